hsv_color_tracker: RTL

//  Sits directly downstream of the RGB->HSV converter. Thresholds each HSV24 pixel into a 1-bit

---
 rtl/hsv_color_tracker_pkg.sv | 24 ++
 rtl/hsv_color_tracker_if.sv | 30 +++
 rtl/hsv_in_range.sv | 18 +
 rtl/hsv_color_tracker.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/hsv_color_tracker_pkg.sv
// Shared types and constants for the HSV colour trackers.
// Holds the FSM encoding, the hue range limit and the default frame geometry.
package hsv_color_tracker_pkg;

  typedef enum logic [1:0] {
    StSync    = 2'd0,
    StActive  = 2'd1,
    StPublish = 2'd2
  } state_e;

  localparam int unsigned HUE_MAX   = 179;
  localparam int unsigned DEF_H_ACT = 1280;
  localparam int unsigned DEF_V_ACT = 720;

  typedef struct packed {
    logic [7:0] h_lo;
    logic [7:0] h_hi;
    logic [7:0] s_lo;
    logic [7:0] s_hi;
    logic [7:0] v_lo;
    logic [7:0] v_hi;
  } window_t;

endpackage

// File: rtl/hsv_color_tracker_if.sv
// Pixel stream in, mask stream and per-frame bounding-box results out.
// The tracker is the slave; the video source / result consumer is the master.
interface hsv_color_tracker_if #(
  parameter int unsigned X_W = 11,
  parameter int unsigned Y_W = 10
);
  logic                 de;
  logic                 vsync;
  logic [23:0]          hsv24;
  logic                 mask;
  logic                 mask_de;
  logic                 mask_vsync;
  logic [X_W-1:0]       x_min;
  logic [X_W-1:0]       x_max;
  logic [Y_W-1:0]       y_min;
  logic [Y_W-1:0]       y_max;
  logic [X_W+Y_W-1:0]   pix_cnt;
  logic                 found;
  logic                 box_valid;

  modport master (
    output de, vsync, hsv24,
    input  mask, mask_de, mask_vsync, x_min, x_max, y_min, y_max, pix_cnt, found, box_valid
  );

  modport slave (
    input  de, vsync, hsv24,
    output mask, mask_de, mask_vsync, x_min, x_max, y_min, y_max, pix_cnt, found, box_valid
  );
endinterface

// File: rtl/hsv_in_range.sv
// Combinational inclusive window compare; with wrap set, lo > hi selects the
// outside-in window used for hues that straddle 0 (e.g. red).
module hsv_in_range (
  input  logic [7:0] value,
  input  logic [7:0] lo,
  input  logic [7:0] hi,
  input  logic       wrap,
  output logic       hit
);
  always_comb begin
    hit = 1'b0;
    if (wrap && (lo > hi)) begin
      hit = (value >= lo) || (value <= hi);
    end else begin
      hit = (value >= lo) && (value <= hi);
    end
  end
endmodule

// File: rtl/hsv_color_tracker.sv
// Thresholds HSV24 pixels into a colour mask and publishes a per-frame bounding
// box and match count, two cycles after each vsync rising edge.
module hsv_color_tracker
  import hsv_color_tracker_pkg::*;
#(
  parameter int unsigned H_ACT   = DEF_H_ACT,
  parameter int unsigned V_ACT   = DEF_V_ACT,
  parameter int unsigned X_W     = 11,
  parameter int unsigned Y_W     = 10,
  parameter int unsigned MIN_PIX = 64
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic [7:0]        h_lo,
  input  logic [7:0]        h_hi,
  input  logic [7:0]        s_lo,
  input  logic [7:0]        s_hi,
  input  logic [7:0]        v_lo,
  input  logic [7:0]        v_hi,
  hsv_color_tracker_if.slave bus
);
  localparam int unsigned      CNT_W   = X_W + Y_W;
  localparam logic [X_W-1:0]   X_LAST  = X_W'(H_ACT - 1);
  localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(V_ACT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIX);

  logic             vsync_q, pix_q;
  logic             vs_rise, pix_ok, line_end;
  window_t          win_q;
  logic             h_ok, s_ok, v_ok, hue_legal, hit;
  logic [X_W-1:0]   x_q;
  logic [Y_W-1:0]   y_q;

  logic [CNT_W-1:0] acc_cnt_q;
  logic [X_W-1:0]   acc_x_min_q, acc_x_max_q;
  logic [Y_W-1:0]   acc_y_min_q, acc_y_max_q;
  logic             acc_found;

  state_e           state_q;
  logic             mask_q, mask_de_q, mask_vsync_q;
  logic             box_valid_q, found_q;
  logic [CNT_W-1:0] cnt_q;
  logic [X_W-1:0]   x_min_q, x_max_q;
  logic [Y_W-1:0]   y_min_q, y_max_q;

  // Pixels presented while vsync is high never count, so line ends track qualified de.
  assign vs_rise   = bus.vsync & ~vsync_q;
  assign pix_ok    = bus.de & ~bus.vsync;
  assign line_end  = pix_q & ~pix_ok;
  assign hue_legal = (bus.hsv24[23:16] <= 8'(HUE_MAX));

  hsv_in_range u_h_range (
    .value(bus.hsv24[23:16]), .lo(win_q.h_lo), .hi(win_q.h_hi), .wrap(1'b1), .hit(h_ok)
  );
  hsv_in_range u_s_range (
    .value(bus.hsv24[15:8]), .lo(win_q.s_lo), .hi(win_q.s_hi), .wrap(1'b0), .hit(s_ok)
  );
  hsv_in_range u_v_range (
    .value(bus.hsv24[7:0]), .lo(win_q.v_lo), .hi(win_q.v_hi), .wrap(1'b0), .hit(v_ok)
  );

  assign hit       = pix_ok & hue_legal & h_ok & s_ok & v_ok;
  assign acc_found = (acc_cnt_q >= MIN_CNT);

  // Edge detectors, frame-aligned threshold shadows and the registered mask path.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q      <= 1'b0;
      pix_q        <= 1'b0;
      win_q        <= '0;
      mask_q       <= 1'b0;
      mask_de_q    <= 1'b0;
      mask_vsync_q <= 1'b0;
    end else begin
      vsync_q      <= bus.vsync;
      pix_q        <= pix_ok;
      mask_q       <= hit;
      mask_de_q    <= bus.de;
      mask_vsync_q <= bus.vsync;
      if (vs_rise) begin
        win_q <= {h_lo, h_hi, s_lo, s_hi, v_lo, v_hi};
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (vs_rise) begin
      x_q <= '0;
      y_q <= '0;
    end else if (line_end) begin
      x_q <= '0;
      if (y_q != Y_LAST) y_q <= y_q + Y_W'(1);
    end else if (pix_ok && (x_q != X_LAST)) begin
      x_q <= x_q + X_W'(1);
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt_q   <= '0;
      acc_x_min_q <= '1;
      acc_x_max_q <= '0;
      acc_y_min_q <= '1;
      acc_y_max_q <= '0;
    end else if (state_q == StPublish) begin
      acc_cnt_q   <= '0;
      acc_x_min_q <= '1;
      acc_x_max_q <= '0;
      acc_y_min_q <= '1;
      acc_y_max_q <= '0;
    end else if ((state_q == StActive) && hit) begin
      if (acc_cnt_q != CNT_MAX) acc_cnt_q <= acc_cnt_q + CNT_W'(1);
      if (x_q < acc_x_min_q) acc_x_min_q <= x_q;
      if (x_q > acc_x_max_q) acc_x_max_q <= x_q;
      if (y_q < acc_y_min_q) acc_y_min_q <= y_q;
      if (y_q > acc_y_max_q) acc_y_max_q <= y_q;
    end
  end

  // The frame in flight at reset is discarded: the first vsync only arms the tracker.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StSync;
      box_valid_q <= 1'b0;
      found_q     <= 1'b0;
      cnt_q       <= '0;
      x_min_q     <= '0;
      x_max_q     <= '0;
      y_min_q     <= '0;
      y_max_q     <= '0;
    end else begin
      box_valid_q <= 1'b0;
      unique case (state_q)
        StSync:   if (vs_rise) state_q <= StActive;
        StActive: if (vs_rise) state_q <= StPublish;
        StPublish: begin
          state_q     <= StActive;
          box_valid_q <= 1'b1;
          cnt_q       <= acc_cnt_q;
          found_q     <= acc_found;
          x_min_q     <= acc_found ? acc_x_min_q : '0;
          x_max_q     <= acc_found ? acc_x_max_q : '0;
          y_min_q     <= acc_found ? acc_y_min_q : '0;
          y_max_q     <= acc_found ? acc_y_max_q : '0;
        end
        default: state_q <= StSync;
      endcase
    end
  end

  assign bus.mask       = mask_q;
  assign bus.mask_de    = mask_de_q;
  assign bus.mask_vsync = mask_vsync_q;
  assign bus.box_valid  = box_valid_q;
  assign bus.found      = found_q;
  assign bus.pix_cnt    = cnt_q;
  assign bus.x_min      = x_min_q;
  assign bus.x_max      = x_max_q;
  assign bus.y_min      = y_min_q;
  assign bus.y_max      = y_max_q;

endmodule
